fft8_sdf_butterfly: RTL and testbench
=====================================

Name: fft8_sdf_butterfly

Overview:
- Radix-2 decimation-in-frequency butterfly for the 8-point FFT datapath, built as a single-path delay-feedback stage.
- Accepts one complex sample per cycle and buffers the first half-frame.
- Emits the sum branch as each second-half sample arrives, then drains the stored difference branch, each tagged with its W8 twiddle index.
- Sits directly upstream of the constant-coefficient complex multiplier (×0.7071) that applies W8^1/W8^3 rotations.

Parameters:
- DW, 16, signed sample width of each real/imag component.
- SCALE, 1, 1 = arithmetic shift right by 1 on every butterfly output (overflow-free); 0 = wrap to DW bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  sample present on in_re/in_im.
- in_ready  output  1  stage can accept a sample this cycle.
- in_re  input  DW  signed real part.
- in_im  input  DW  signed imag part.
- out_valid  output  1  out_* fields valid this cycle.
- out_re  output  DW  signed real result.
- out_im  output  DW  signed imag result.
- out_tw  output  2  twiddle index k for the downstream multiplier; 0 on the sum branch.
- out_last  output  1  final output of the frame.

Behaviour:
- Frame = 8 samples x[0..7], in order. A sample is accepted when in_valid && in_ready. Bubbles (in_valid=0) are allowed anywhere in a frame; the count advances only on accepts.
- Reset: state=FILL, cnt=0, in_ready=0 in the reset cycle and 1 the cycle after. out_valid, out_re, out_im, out_tw, out_last all 0. Buffer contents are don't-care. Reset mid-frame discards the partial frame and any pending drain.
- State FILL (cnt 0..3), in_ready=1:
  - An accepted x[cnt] is written to buf[cnt]; cnt++.
  - After cnt=3 is accepted, go to PAIR.
- State PAIR (cnt 4..7), in_ready=1:
  - For an accepted b=x[cnt], take a=buf[cnt-4].
  - Register out = (a+b) on the next cycle with out_valid=1 and out_tw=0.
  - Write (a−b) into buf[cnt-4] in the same cycle.
  - After cnt=7 is accepted, go to DRAIN.
- State DRAIN, in_ready=0:
  - For 4 consecutive cycles, drive buf[j] with out_tw=j, j=0..3, out_valid=1.
  - out_last=1 only with j=3.
  - After j=3, go to FILL with cnt=0; in_ready returns to 1 the cycle after the last drain output.
- Latency:
  - The sum output appears 1 cycle after its b sample is accepted.
  - The first drain output immediately follows the 4th sum output (cycle after it), with no gap.
  - Output order is always 4 sums then 4 differences (8 outputs per frame).
- Arithmetic:
  - Sums and differences are computed at DW+1 bits with sign extension.
  - SCALE=1: result = (DW+1)-bit value >>> 1 (floor), so it never overflows.
  - SCALE=0: result = low DW bits (two's-complement wrap).
- out_valid=0 in every cycle that produces no output. out_re/out_im/out_tw hold their last value when out_valid=0; out_last is 0.
- There is no output backpressure: the downstream stage is always ready.

Test Plan:
- Ramp, SCALE=1: in_re=0,100,…,700, in_im=0, back-to-back -> sums out_re=200,300,400,500 (tw 0); then diffs −200 ×4 with tw=0,1,2,3; out_last only on the 8th output; in_ready low for exactly the 4 drain cycles.
- Overflow, SCALE=1: pair a=32767, b=32767 -> sum 32767; pair a=−32768, b=32767 -> diff −32768 (floor); imag a=−32768, b=−32768 -> sum −32768.
- Wrap, SCALE=0: a=30000, b=10000 -> sum 40000 wraps to −25536; diff 20000.
- Bubbles: in_valid toggling 1,0,1,0… over a full frame -> same 8 output values as the ramp case; each sum appears exactly 1 cycle after its accepted b; drain output is still 4 contiguous cycles.
- Reset mid-frame: assert rst after 6 accepts -> next cycle all outputs 0; a fresh 8-sample frame afterwards produces the correct 8 outputs with no stale data.
- Back-to-back frames: two ramp frames streamed with in_valid held high -> the second frame's x[0] is accepted on the first cycle in_ready returns to 1; 16 correct outputs and exactly 2 out_last pulses.

Source files
------------

// File: rtl/fft8_sdf_butterfly.sv
// ---------------------------------------------------------------------------
// fft8_sdf_butterfly
//
// Radix-2 DIF butterfly stage for an 8-point FFT, single-path delay-feedback
// style. The first half-frame x[0..3] is parked in a 4-entry buffer. Each
// second-half sample x[k+4] pairs with x[k]:
//   - the sum is emitted on the next cycle with twiddle index 0;
//   - the difference overwrites buf[k].
// After x[7] the four stored differences are drained on consecutive cycles
// with twiddle index k. The final drain output carries out_last.
//
// Parameters
//   DW     width of each signed real/imag component
//   SCALE  1: butterfly results are (DW+1)-bit values shifted right by one
//             (floor), so they never overflow
//          0: butterfly results wrap to DW bits
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset; drops any partial frame/drain
//   in_valid   sample present on in_re/in_im
//   in_ready   stage accepts a sample this cycle (low while draining)
//   in_re/im   signed input sample
//   out_valid  out_* fields valid this cycle
//   out_re/im  signed butterfly result (held while out_valid=0)
//   out_tw     W8 twiddle index for the downstream rotator (0 on sums)
//   out_last   final output of the frame
// ---------------------------------------------------------------------------
module fft8_sdf_butterfly #(
  parameter int DW    = 16,
  parameter int SCALE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_re,
  input  logic signed [DW-1:0] in_im,
  output logic                 out_valid,
  output logic signed [DW-1:0] out_re,
  output logic signed [DW-1:0] out_im,
  output logic [1:0]           out_tw,
  output logic                 out_last
);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    PAIR  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t     state_reg, state_next;
  // Position inside the current quarter of work: buffer slot in FILL/PAIR,
  // drain index j in DRAIN. The state itself tells which half we are in.
  logic [1:0] idx_reg, idx_next;

  // Four-entry half-frame buffer. It is read in the same cycle as the
  // paired sample arrives, so the read is combinational from a small array.
  logic [DW-1:0] buf_re_reg [4];
  logic [DW-1:0] buf_im_reg [4];
  logic          buf_we;
  logic [DW-1:0] buf_wr_re, buf_wr_im;

  logic          out_valid_reg, out_valid_next;
  logic [DW-1:0] out_re_reg, out_re_next;
  logic [DW-1:0] out_im_reg, out_im_next;
  logic [1:0]    out_tw_reg, out_tw_next;
  logic          out_last_reg, out_last_next;

  logic          accept;
  logic [DW-1:0] rd_re, rd_im;
  logic [DW:0]   sum_re, sum_im, dif_re, dif_im;

  // Bring a (DW+1)-bit butterfly result back to DW bits.
  function automatic logic [DW-1:0] fit(input logic [DW:0] v);
    if (SCALE != 0) fit = v[DW:1];
    else            fit = v[DW-1:0];
  endfunction

  assign in_ready = ~rst && (state_reg != DRAIN);
  assign accept   = in_valid && in_ready;

  assign rd_re = buf_re_reg[idx_reg];
  assign rd_im = buf_im_reg[idx_reg];

  // Sign-extend both operands by one bit so the raw result cannot overflow.
  assign sum_re = {rd_re[DW-1], rd_re} + {in_re[DW-1], in_re};
  assign sum_im = {rd_im[DW-1], rd_im} + {in_im[DW-1], in_im};
  assign dif_re = {rd_re[DW-1], rd_re} - {in_re[DW-1], in_re};
  assign dif_im = {rd_im[DW-1], rd_im} - {in_im[DW-1], in_im};

  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    buf_we         = 1'b0;
    buf_wr_re      = in_re;
    buf_wr_im      = in_im;
    out_valid_next = 1'b0;
    out_last_next  = 1'b0;
    out_re_next    = out_re_reg;
    out_im_next    = out_im_reg;
    out_tw_next    = out_tw_reg;

    case (state_reg)
      FILL: begin
        if (accept) begin
          buf_we   = 1'b1;
          idx_next = idx_reg + 2'd1;
          if (idx_reg == 2'd3) state_next = PAIR;
        end
      end

      PAIR: begin
        if (accept) begin
          buf_we         = 1'b1;
          buf_wr_re      = fit(dif_re);
          buf_wr_im      = fit(dif_im);
          out_valid_next = 1'b1;
          out_re_next    = fit(sum_re);
          out_im_next    = fit(sum_im);
          out_tw_next    = 2'd0;
          idx_next       = idx_reg + 2'd1;
          if (idx_reg == 2'd3) state_next = DRAIN;
        end
      end

      DRAIN: begin
        // Differences leave in buffer order; slot j carries twiddle W8^j.
        out_valid_next = 1'b1;
        out_re_next    = rd_re;
        out_im_next    = rd_im;
        out_tw_next    = idx_reg;
        out_last_next  = (idx_reg == 2'd3);
        idx_next       = idx_reg + 2'd1;
        if (idx_reg == 2'd3) state_next = FILL;
      end

      default: begin
        state_next = FILL;
        idx_next   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= FILL;
      idx_reg       <= 2'd0;
      out_valid_reg <= 1'b0;
      out_re_reg    <= '0;
      out_im_reg    <= '0;
      out_tw_reg    <= 2'd0;
      out_last_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      out_valid_reg <= out_valid_next;
      out_re_reg    <= out_re_next;
      out_im_reg    <= out_im_next;
      out_tw_reg    <= out_tw_next;
      out_last_reg  <= out_last_next;
    end
  end

  // Buffer contents need no reset; a new frame always rewrites every slot
  // before it is read.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      buf_re_reg[idx_reg] <= buf_wr_re;
      buf_im_reg[idx_reg] <= buf_wr_im;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_re    = out_re_reg;
  assign out_im    = out_im_reg;
  assign out_tw    = out_tw_reg;
  assign out_last  = out_last_reg;

endmodule

// File: tb/tb_fft8_sdf_butterfly.sv
// ---------------------------------------------------------------------------
// tb_fft8_sdf_butterfly
//
// Drives one input stream into two instances (SCALE=1 and SCALE=0) and
// checks both against a frame-level reference: the 8 outputs of a frame are
// computed from x[k] +/- x[k+4] with plain integer arithmetic and scheduled
// on the cycles at which they must appear.
// ---------------------------------------------------------------------------
module tb_fft8_sdf_butterfly;

  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst      = 1'b1;
  logic                 in_valid = 1'b0;
  logic signed [DW-1:0] in_re    = '0;
  logic signed [DW-1:0] in_im    = '0;

  logic                 rdy1, ov1, ol1, rdy0, ov0, ol0;
  logic signed [DW-1:0] ore1, oim1, ore0, oim0;
  logic [1:0]           otw1, otw0;

  fft8_sdf_butterfly #(.DW(DW), .SCALE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
    .in_re(in_re), .in_im(in_im), .out_valid(ov1), .out_re(ore1),
    .out_im(oim1), .out_tw(otw1), .out_last(ol1)
  );

  fft8_sdf_butterfly #(.DW(DW), .SCALE(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0),
    .in_re(in_re), .in_im(in_im), .out_valid(ov0), .out_re(ore0),
    .out_im(oim0), .out_tw(otw0), .out_last(ol0)
  );

  typedef struct {
    int                   cyc;
    logic signed [DW-1:0] re1, im1, re0, im0;
    logic [1:0]           tw;
    logic                 last;
  } exp_t;

  exp_t q[$];
  int   errors = 0, checks = 0;
  int   cur = 0, low_until = -1, pos = 0, last_pulses = 0;
  int   fx_re[8], fx_im[8];
  logic signed [DW-1:0] held_re1 = '0, held_im1 = '0, held_re0 = '0, held_im0 = '0;
  logic [1:0]           held_tw1 = '0, held_tw0 = '0;
  logic signed [DW-1:0] src_re[$], src_im[$];
  logic signed [DW-1:0] cap_re1[$], cap_im1[$], cap_re0[$];
  logic [1:0]           cap_tw1[$];
  logic                 cap_last1[$];

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [DW-1:0] sc1(input int s);
    int t;
    t = s >>> 1;
    return t[DW-1:0];
  endfunction

  function automatic logic signed [DW-1:0] sc0(input int s);
    return s[DW-1:0];
  endfunction

  // Reference: record accepted sample; schedule sums/diffs by cycle.
  task automatic model_accept(input logic signed [DW-1:0] re,
                              input logic signed [DW-1:0] im);
    exp_t e;
    int   k, sr, si;
    fx_re[pos] = int'(re);
    fx_im[pos] = int'(im);
    if (pos >= 4) begin
      k = pos - 4;
      sr = fx_re[k] + fx_re[pos];
      si = fx_im[k] + fx_im[pos];
      e.cyc = cur + 1; e.re1 = sc1(sr); e.im1 = sc1(si);
      e.re0 = sc0(sr); e.im0 = sc0(si); e.tw = 2'd0; e.last = 1'b0;
      q.push_back(e);
    end
    if (pos == 7) begin
      for (int j = 0; j < 4; j++) begin
        sr = fx_re[j] - fx_re[j+4];
        si = fx_im[j] - fx_im[j+4];
        e.cyc = cur + 2 + j; e.re1 = sc1(sr); e.im1 = sc1(si);
        e.re0 = sc0(sr); e.im0 = sc0(si); e.tw = 2'(j); e.last = (j == 3);
        q.push_back(e);
      end
      low_until = cur + 4;
      pos = 0;
    end else begin
      pos++;
    end
  endtask

  task automatic check_outputs();
    exp_t e;
    if (q.size() > 0 && q[0].cyc == cur) begin
      e = q.pop_front();
      chk("valid1", ov1, 1);     chk("valid0", ov0, 1);
      chk("re1", ore1, e.re1);   chk("im1", oim1, e.im1);
      chk("re0", ore0, e.re0);   chk("im0", oim0, e.im0);
      chk("tw1", otw1, e.tw);    chk("tw0", otw0, e.tw);
      chk("last1", ol1, e.last); chk("last0", ol0, e.last);
      held_re1 = e.re1; held_im1 = e.im1; held_re0 = e.re0; held_im0 = e.im0;
      held_tw1 = e.tw;  held_tw0 = e.tw;
      $display("cyc=%0d out re=%0d im=%0d tw=%0d last=%0d | wrap re=%0d im=%0d",
               cur, ore1, oim1, otw1, ol1, ore0, oim0);
    end else begin
      chk("idle_valid1", ov1, 0); chk("idle_valid0", ov0, 0);
      chk("idle_last1", ol1, 0);  chk("idle_last0", ol0, 0);
      chk("hold_re1", ore1, held_re1); chk("hold_im1", oim1, held_im1);
      chk("hold_re0", ore0, held_re0); chk("hold_im0", oim0, held_im0);
      chk("hold_tw1", otw1, held_tw1); chk("hold_tw0", otw0, held_tw0);
    end
    if (ov1 === 1'b1) begin
      cap_re1.push_back(ore1); cap_im1.push_back(oim1); cap_re0.push_back(ore0);
      cap_tw1.push_back(otw1); cap_last1.push_back(ol1);
    end
    if (ol1 === 1'b1) last_pulses++;
  endtask

  task automatic step(input bit v, input logic signed [DW-1:0] re,
                      input logic signed [DW-1:0] im, output bit acc);
    bit mready;
    rst = 1'b0; in_valid = v; in_re = re; in_im = im;
    #1;
    mready = (cur > low_until);
    chk("in_ready1", rdy1, mready);
    chk("in_ready0", rdy0, mready);
    acc = v && mready;
    if (acc) model_accept(re, im);
    @(posedge clk); #1;
    cur++;
    check_outputs();
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      rst = 1'b1; in_valid = 1'b1;
      in_re = DW'($urandom); in_im = DW'($urandom);
      #1;
      chk("rst_ready1", rdy1, 0); chk("rst_ready0", rdy0, 0);
      @(posedge clk); #1;
      cur++;
      q.delete(); pos = 0; low_until = -1;
      held_re1 = '0; held_im1 = '0; held_re0 = '0; held_im0 = '0;
      held_tw1 = '0; held_tw0 = '0;
      chk("rst_valid1", ov1, 0); chk("rst_re1", ore1, 0); chk("rst_im1", oim1, 0);
      chk("rst_tw1", otw1, 0);   chk("rst_last1", ol1, 0);
      chk("rst_valid0", ov0, 0); chk("rst_re0", ore0, 0); chk("rst_im0", oim0, 0);
      chk("rst_tw0", otw0, 0);   chk("rst_last0", ol0, 0);
    end
  endtask

  // mode 0: valid held high, 1: alternating, 2: random
  task automatic feed(input int mode);
    bit acc, v, tog;
    int guard;
    tog = 1'b1; guard = 0;
    while (src_re.size() > 0 && guard < 2000) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = tog;
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      tog = ~tog;
      step(v, v ? src_re[0] : DW'($urandom), v ? src_im[0] : DW'($urandom), acc);
      if (acc) begin
        void'(src_re.pop_front());
        void'(src_im.pop_front());
      end
      guard++;
    end
    chk("feed_pending", src_re.size(), 0);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, DW'($urandom), DW'($urandom), acc);
  endtask

  task automatic push_ramp();
    for (int i = 0; i < 8; i++) begin
      src_re.push_back(DW'(100 * i));
      src_im.push_back('0);
    end
  endtask

  task automatic clear_caps();
    cap_re1.delete(); cap_im1.delete(); cap_re0.delete();
    cap_tw1.delete(); cap_last1.delete();
  endtask

  // Ramp frame, SCALE=1: sums 200..500, diffs -200 with tw 0..3.
  task automatic check_ramp_caps(input string tag);
    int exp_re[8];
    exp_re = '{200, 300, 400, 500, -200, -200, -200, -200};
    chk({tag, "_count"}, cap_re1.size(), 8);
    if (cap_re1.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk({tag, "_re"}, cap_re1[i], exp_re[i]);
        chk({tag, "_tw"}, cap_tw1[i], (i < 4) ? 0 : i - 4);
        chk({tag, "_last"}, cap_last1[i], (i == 7) ? 1 : 0);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  initial begin
    logic signed [DW-1:0] ov_re[8], ov_im[8];

    do_reset(2);

    // Ramp, back-to-back.
    clear_caps();
    push_ramp();
    feed(0);
    idle(6);
    check_ramp_caps("ramp");

    // Overflow / wrap corner pairs in one frame.
    ov_re = '{16'sd32767, -16'sd32768, 16'sd0, 16'sd30000,
              16'sd32767,  16'sd32767, 16'sd0, 16'sd10000};
    ov_im = '{16'sd0, 16'sd0, -16'sd32768, 16'sd0,
              16'sd0, 16'sd0, -16'sd32768, 16'sd0};
    clear_caps();
    for (int i = 0; i < 8; i++) begin
      src_re.push_back(ov_re[i]);
      src_im.push_back(ov_im[i]);
    end
    feed(0);
    idle(6);
    chk("ovf_count", cap_re1.size(), 8);
    if (cap_re1.size() == 8) begin
      chk("ovf_sum_max", cap_re1[0], 32767);
      chk("ovf_diff_floor", cap_re1[5], -32768);
      chk("ovf_sum_min_im", cap_im1[2], -32768);
      chk("wrap_sum", cap_re0[3], -25536);
      chk("wrap_diff", cap_re0[7], 20000);
    end

    // Bubbles: alternating valid gives the same ramp results.
    clear_caps();
    push_ramp();
    feed(1);
    idle(6);
    check_ramp_caps("bubble");

    // Reset after 6 accepts, then a clean frame.
    for (int i = 0; i < 6; i++) begin
      src_re.push_back(DW'($urandom));
      src_im.push_back(DW'($urandom));
    end
    feed(0);
    do_reset(1);
    clear_caps();
    push_ramp();
    feed(0);
    idle(6);
    check_ramp_caps("post_rst");

    // Two frames with in_valid held high across the drain.
    clear_caps();
    last_pulses = 0;
    push_ramp();
    push_ramp();
    feed(0);
    idle(6);
    chk("b2b_count", cap_re1.size(), 16);
    chk("b2b_last_pulses", last_pulses, 2);

    // Random data and random bubbles over several frames.
    for (int i = 0; i < 40; i++) begin
      src_re.push_back(DW'($urandom));
      src_im.push_back(DW'($urandom));
    end
    feed(2);
    idle(6);
    chk("rand_queue_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
